intersection_scheduler: RTL and testbench

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

---
 rtl/isi_pkg.sv | 38 +++
 rtl/intersection_scheduler_if.sv | 30 +++
 rtl/intersection_scheduler_tick_gen.sv | 22 ++
 rtl/intersection_scheduler.sv | 124 ++++++++++++
 tb/tb_intersection_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/isi_pkg.sv
// isi_pkg: state encoding, direction constants and lamp codes shared by the intersection scheduler.
package isi_pkg;

    typedef enum logic [3:0] {
        NS_G,
        NS_Y,
        AR1,
        EW_G,
        EW_Y,
        AR2,
        PRE_Y,
        PRE_AR,
        PRE_G,
        PRE_EXIT
    } state_e;

    localparam logic NS = 1'b0;
    localparam logic EW = 1'b1;

    typedef struct packed {
        logic green;
        logic yellow;
        logic red;
    } lamp_t;

    localparam lamp_t LAMP_G = 3'b100;
    localparam lamp_t LAMP_Y = 3'b010;
    localparam lamp_t LAMP_R = 3'b001;

    function automatic logic is_pre(state_e s);
        return s inside {PRE_Y, PRE_AR, PRE_G, PRE_EXIT};
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if: request inputs and registered lamp outputs of the intersection scheduler.
interface intersection_scheduler_if;

    logic ped_ns_req;
    logic ped_ew_req;
    logic emg_req;
    logic emg_dir;
    logic green_ns;
    logic yello_ns;
    logic red_ns;
    logic green_ew;
    logic yello_ew;
    logic red_ew;
    logic walk_ns;
    logic walk_ew;
    logic emg_active;

    modport master (
        output ped_ns_req, ped_ew_req, emg_req, emg_dir,
        input  green_ns, yello_ns, red_ns, green_ew, yello_ew, red_ew,
        input  walk_ns, walk_ew, emg_active
    );

    modport slave (
        input  ped_ns_req, ped_ew_req, emg_req, emg_dir,
        output green_ns, yello_ns, red_ns, green_ew, yello_ew, red_ew,
        output walk_ns, walk_ew, emg_active
    );

endinterface

// File: rtl/intersection_scheduler_tick_gen.sv
// tick_gen: free-running prescaler that pulses tick for one clk every TICK_DIV clks.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-way traffic light controller with pedestrian requests and emergency preempt.
module intersection_scheduler
    import isi_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int T_GREEN     = 8,
    parameter int T_MIN_GREEN = 3,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 4
) (
    input logic                     clk,
    input logic                     rst,
    intersection_scheduler_if.slave bus
);

    localparam int T_MAX = imax(imax(imax(T_GREEN, T_MIN_GREEN), imax(T_YELLOW, T_ALLRED)), T_WALK);
    localparam int TW    = $clog2(T_MAX) + 1;

    logic          tick;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic          wen_ns_q, wen_ns_d, wen_ew_q, wen_ew_d;
    logic          emg_pend_q, emg_pend_d, emg_dir_q, emg_dir_d;
    lamp_t         ns_q, ns_d, ew_q, ew_d;
    logic          walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic          emg_act_q, emg_act_d;
    logic          pre_now, dir_now, chg, exit_y;
    logic          ns_end, ew_end, y_end, ar_end, ex_end;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        // a preempt latched earlier wins over a fresh emg_dir sample
        pre_now = emg_pend_q | bus.emg_req;
        dir_now = emg_pend_q ? emg_dir_q : bus.emg_dir;
        ns_end  = tick && (int'(timer_q) == T_GREEN - 1 || (pend_ew_q && int'(timer_q) >= T_MIN_GREEN - 1));
        ew_end  = tick && (int'(timer_q) == T_GREEN - 1 || (pend_ns_q && int'(timer_q) >= T_MIN_GREEN - 1));
        y_end   = tick && int'(timer_q) == T_YELLOW - 1;
        ar_end  = tick && int'(timer_q) == T_ALLRED - 1;
        ex_end  = tick && int'(timer_q) == T_YELLOW + T_ALLRED - 1;
        case (state_q)
            NS_G:     state_d = pre_now ? ((dir_now == NS) ? PRE_G : PRE_Y) : (ns_end ? NS_Y : NS_G);
            NS_Y:     state_d = y_end ? (pre_now ? PRE_AR : AR1) : NS_Y;
            AR1:      state_d = ar_end ? (pre_now ? PRE_AR : EW_G) : AR1;
            EW_G:     state_d = pre_now ? ((dir_now == EW) ? PRE_G : PRE_Y) : (ew_end ? EW_Y : EW_G);
            EW_Y:     state_d = y_end ? (pre_now ? PRE_AR : AR2) : EW_Y;
            AR2:      state_d = ar_end ? (pre_now ? PRE_AR : NS_G) : AR2;
            PRE_Y:    state_d = y_end ? PRE_AR : PRE_Y;
            PRE_AR:   state_d = ar_end ? PRE_G : PRE_AR;
            PRE_G:    state_d = bus.emg_req ? PRE_G : PRE_EXIT;
            PRE_EXIT: state_d = ex_end ? ((emg_dir_q == NS) ? EW_G : NS_G) : PRE_EXIT;
            default:  state_d = AR2;
        endcase
        chg        = (state_d != state_q);
        timer_d    = chg ? '0 : (tick ? timer_q + TW'(1) : timer_q);
        pend_ns_d  = (pend_ns_q && !(chg && state_d == NS_G)) || bus.ped_ns_req;
        pend_ew_d  = (pend_ew_q && !(chg && state_d == EW_G)) || bus.ped_ew_req;
        wen_ns_d   = chg ? (state_d == NS_G && pend_ns_q) : wen_ns_q;
        wen_ew_d   = chg ? (state_d == EW_G && pend_ew_q) : wen_ew_q;
        emg_pend_d = !is_pre(state_q) && !is_pre(state_d) && pre_now;
        emg_dir_d  = (!is_pre(state_q) && !emg_pend_q && bus.emg_req) ? bus.emg_dir : emg_dir_q;
        // PRE_EXIT spends its first T_YELLOW ticks in yellow, the rest all-red
        exit_y     = (state_q == PRE_EXIT) && int'(timer_q) < T_YELLOW;
        ns_d       = (state_q == NS_G || (state_q == PRE_G && emg_dir_q == NS)) ? LAMP_G :
                     (state_q == NS_Y || (state_q == PRE_Y && emg_dir_q == EW) ||
                      (exit_y && emg_dir_q == NS)) ? LAMP_Y : LAMP_R;
        ew_d       = (state_q == EW_G || (state_q == PRE_G && emg_dir_q == EW)) ? LAMP_G :
                     (state_q == EW_Y || (state_q == PRE_Y && emg_dir_q == NS) ||
                      (exit_y && emg_dir_q == EW)) ? LAMP_Y : LAMP_R;
        walk_ns_d  = (state_q == NS_G) && wen_ns_q && int'(timer_q) < T_WALK;
        walk_ew_d  = (state_q == EW_G) && wen_ew_q && int'(timer_q) < T_WALK;
        emg_act_d  = (state_q == PRE_G);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= AR2;
            timer_q    <= '0;
            pend_ns_q  <= 1'b0;
            pend_ew_q  <= 1'b0;
            wen_ns_q   <= 1'b0;
            wen_ew_q   <= 1'b0;
            emg_pend_q <= 1'b0;
            emg_dir_q  <= NS;
            ns_q       <= LAMP_R;
            ew_q       <= LAMP_R;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            emg_act_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_ns_q  <= pend_ns_d;
            pend_ew_q  <= pend_ew_d;
            wen_ns_q   <= wen_ns_d;
            wen_ew_q   <= wen_ew_d;
            emg_pend_q <= emg_pend_d;
            emg_dir_q  <= emg_dir_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            emg_act_q  <= emg_act_d;
        end
    end

    assign bus.green_ns   = ns_q.green;
    assign bus.yello_ns   = ns_q.yellow;
    assign bus.red_ns     = ns_q.red;
    assign bus.green_ew   = ew_q.green;
    assign bus.yello_ew   = ew_q.yellow;
    assign bus.red_ew     = ew_q.red;
    assign bus.walk_ns    = walk_ns_q;
    assign bus.walk_ew    = walk_ew_q;
    assign bus.emg_active = emg_act_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed scenarios with hand-computed lamp timelines for intersection_scheduler.
module tb_intersection_scheduler;

    localparam logic [5:0] R  = 6'b001_001;
    localparam logic [5:0] NG = 6'b100_001;
    localparam logic [5:0] NY = 6'b010_001;
    localparam logic [5:0] EG = 6'b001_100;
    localparam logic [5:0] EY = 6'b001_010;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    intersection_scheduler_if bus();

    intersection_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {lamps_ns, lamps_ew, walk_ns, walk_ew, emg_active}
    function automatic logic [8:0] obs();
        return {bus.green_ns, bus.yello_ns, bus.red_ns, bus.green_ew, bus.yello_ew, bus.red_ew,
                bus.walk_ns, bus.walk_ew, bus.emg_active};
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            total++;
            if (!$onehot({bus.green_ns, bus.yello_ns, bus.red_ns}) ||
                !$onehot({bus.green_ew, bus.yello_ew, bus.red_ew}) ||
                (bus.green_ns && bus.green_ew) ||
                ((bus.walk_ns || bus.walk_ew) && (bus.yello_ns || bus.yello_ew))) begin
                bad++;
                $display("FAIL lamp_rules cyc=%0d got=%b", cyc, obs());
            end
        end
    end

    task automatic go_to(input int k);
        if (cyc < k) begin
            while (cyc < k) begin
                @(posedge clk);
                cyc++;
            end
            #1;
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        bus.ped_ns_req = 1'b0;
        bus.ped_ew_req = 1'b0;
        bus.emg_req    = 1'b0;
        bus.emg_dir    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ped_ns_req = 1'b0;
        bus.ped_ew_req = 1'b0;
        bus.emg_req    = 1'b0;
        bus.emg_dir    = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (obs() !== {R, 3'b000}) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", obs(), {R, 3'b000});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== {R, 3'b000}) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", obs(), {R, 3'b000});
        end
    endtask

    task automatic test_normal_cycle();
        int         ck[16] = '{4, 5, 36, 37, 48, 49, 52, 53, 84, 85, 96, 97, 100, 101, 132, 133};
        logic [5:0] ex[16] = '{R, NG, NG, NY, NY, R, R, EG, EG, EY, EY, R, R, NG, NG, NY};
        restart();
        for (int i = 0; i < 16; i++) begin
            go_to(ck[i]);
            total++;
            if (obs() !== {ex[i], 3'b000}) begin
                bad++;
                $display("FAIL normal_cycle cyc=%0d got=%b exp=%b", cyc, obs(), {ex[i], 3'b000});
            end
        end
    endtask

    task automatic test_ped_early();
        int         ck[14] = '{16, 17, 28, 29, 32, 33, 48, 49, 64, 65, 81, 93, 112, 113};
        logic [8:0] ex[14] = '{{NG, 3'b000}, {NY, 3'b000}, {NY, 3'b000}, {R, 3'b000}, {R, 3'b000},
                               {EG, 3'b010}, {EG, 3'b010}, {EG, 3'b000}, {EG, 3'b000}, {EY, 3'b000},
                               {NG, 3'b000}, {NG, 3'b000}, {NG, 3'b000}, {NY, 3'b000}};
        restart();
        go_to(4);
        bus.ped_ew_req = 1'b1;
        go_to(5);
        bus.ped_ew_req = 1'b0;
        for (int i = 0; i < 14; i++) begin
            go_to(ck[i]);
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL ped_early cyc=%0d got=%b exp=%b", cyc, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_emg_ew();
        int         ck[16] = '{11, 12, 20, 21, 24, 25, 30, 45, 61, 62, 72, 73, 76, 77, 92, 93};
        logic [8:0] ex[16] = '{{NG, 3'b000}, {NY, 3'b000}, {NY, 3'b000}, {R, 3'b000}, {R, 3'b000},
                               {EG, 3'b001}, {EG, 3'b001}, {EG, 3'b001}, {EG, 3'b001}, {EY, 3'b000},
                               {EY, 3'b000}, {R, 3'b000}, {R, 3'b000}, {NG, 3'b100}, {NG, 3'b100},
                               {NG, 3'b000}};
        int j = 0;
        restart();
        for (int c = 1; c <= 93; c++) begin
            go_to(c);
            if (j < 16 && c == ck[j]) begin
                total++;
                if (obs() !== ex[j]) begin
                    bad++;
                    $display("FAIL emg_ew cyc=%0d got=%b exp=%b", cyc, obs(), ex[j]);
                end
                j++;
            end
            if (c == 10) begin
                bus.emg_req = 1'b1;
                bus.emg_dir = 1'b1;
            end
            bus.ped_ns_req = (c == 30);
            if (c == 60) bus.emg_req = 1'b0;
        end
    endtask

    task automatic test_emg_ns_reset();
        restart();
        for (int c = 1; c <= 40; c++) begin
            go_to(c);
            if (c >= 5) begin
                total++;
                if (bus.green_ns !== 1'b1) begin
                    bad++;
                    $display("FAIL emg_ns_green cyc=%0d got=%b exp=1", cyc, bus.green_ns);
                end
            end
            if (c == 11 || c == 12 || c == 40) begin
                total++;
                if (bus.emg_active !== (c != 11)) begin
                    bad++;
                    $display("FAIL emg_ns_active cyc=%0d got=%b exp=%b", cyc, bus.emg_active, c != 11);
                end
            end
            if (c == 10) begin
                bus.emg_req = 1'b1;
                bus.emg_dir = 1'b0;
            end
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs() !== {R, 3'b000}) begin
            bad++;
            $display("FAIL reset_in_pre_g got=%b exp=%b", obs(), {R, 3'b000});
        end
        bus.emg_req = 1'b0;
    endtask

    task automatic test_yellow_preempt();
        int         ck[9] = '{48, 49, 52, 53, 57, 58, 68, 69, 73};
        logic [8:0] ex[9] = '{{NY, 3'b000}, {R, 3'b000}, {R, 3'b000}, {NG, 3'b001}, {NG, 3'b001},
                              {NY, 3'b000}, {NY, 3'b000}, {R, 3'b000}, {EG, 3'b000}};
        int j = 0;
        restart();
        for (int c = 1; c <= 73; c++) begin
            go_to(c);
            if (j < 9 && c == ck[j]) begin
                total++;
                if (obs() !== ex[j]) begin
                    bad++;
                    $display("FAIL yellow_preempt cyc=%0d got=%b exp=%b", cyc, obs(), ex[j]);
                end
                j++;
            end
            if (c == 40) begin
                bus.emg_req = 1'b1;
                bus.emg_dir = 1'b0;
            end
            if (c == 56) bus.emg_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int         ck[7] = '{25, 62, 70, 74, 77, 78, 90};
        logic [8:0] ex[7] = '{{EG, 3'b001}, {EY, 3'b000}, {EY, 3'b000}, {R, 3'b000}, {NG, 3'b000},
                              {NG, 3'b001}, {NG, 3'b001}};
        int j = 0;
        restart();
        for (int c = 1; c <= 90; c++) begin
            go_to(c);
            if (j < 7 && c == ck[j]) begin
                total++;
                if (obs() !== ex[j]) begin
                    bad++;
                    $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs(), ex[j]);
                end
                j++;
            end
            if (c == 10) begin
                bus.emg_req = 1'b1;
                bus.emg_dir = 1'b1;
            end
            if (c == 60) bus.emg_req = 1'b0;
            if (c == 66) begin
                bus.emg_req = 1'b1;
                bus.emg_dir = 1'b0;
            end
        end
        bus.emg_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_early();
        test_emg_ew();
        test_emg_ns_reset();
        test_yellow_preempt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
